adc_scan_sequencer: RTL and testbench
=====================================

// Module: adc_scan_sequencer
// PURPOSE
// - Round-robin scan controller for the on-board LTC2308 8-channel 12-bit SPI ADC.
//   Sits between the ADC pins (ADC_CONVST/ADC_SCK/ADC_SDI/ADC_SDO) and fabric consumers such as the forklift sensor logic.
// - Sequences conversion, config shift and result shift per frame, compensating for the ADC's one-frame result pipeline.
// - Emits one tagged sample per enabled channel per frame.
// PARAMETERS
// - SCK_DIV      default 2    clk cycles per SCK half-period; SCK = clk/(2*SCK_DIV); min 1
// - CONV_CYCLES  default 80   clk cycles CONVST held high (1.6 us at 50 MHz, >= tCONV)
// - GAP_CYCLES   default 100  idle clk cycles between frames; 0 allowed
// PORTS
// - clk          in   1   system clock, 50 MHz
// - reset_n      in   1   asynchronous active-low reset
// - enable       in   1   1 = scan; 0 = stop after the current frame
// - ch_mask      in   8   bit n = scan channel n
// - adc_convst   out  1   ADC CONVST (wired to ADC_CONVST)
// - adc_sclk     out  1   ADC SCK, idles low
// - adc_din      out  1   ADC SDI, config word MSB-first
// - adc_dout     in   1   ADC SDO
// - sample_valid out  1   1-cycle strobe, sample_ch/sample_data valid
// - sample_ch    out  3   channel of the returned sample
// - sample_data  out  12  unsigned unipolar result
// - busy         out  1   1 whenever FSM not in IDLE
// BEHAVIOUR
// - Reset: all outputs 0, FSM IDLE, primed=0, cur_ch=0, prev_ch=0. Async assert, sync deassert handled upstream.
// - FSM: IDLE -> CONV -> SHIFT -> GAP -> (CONV | IDLE).
// - IDLE: leave when enable=1 and ch_mask!=0. Latch next channel = lowest set bit of ch_mask above prev_ch, wrapping 7->0.
//   - On first entry, search starts at channel 0.
// - CONV: adc_convst=1 for CONV_CYCLES, then 0. Enter SHIFT on the next cycle.
// - SHIFT: 12 SCK pulses. adc_din updates while SCK is low, one SCK_DIV period before each rising edge.
//   - Config bits 11..6 = {1'b1, ch[0], ch[2], ch[1], 1'b1, 1'b0} (single-ended, unipolar, no sleep); bits 5..0 driven 0.
//   - adc_dout sampled on each rising SCK edge, MSB first, into a 12-bit shift register.
// - End of SHIFT, i.e. the cycle after the 12th falling SCK edge:
//   - If primed=1, pulse sample_valid with sample_ch=prev_ch and sample_data=shift register.
//   - Then set prev_ch=cur_ch and primed=1.
// - GAP: wait GAP_CYCLES. Then:
//   - If enable=0 or ch_mask==0, go to IDLE and clear primed.
//   - Otherwise compute the next channel and go to CONV.
// - ch_mask is sampled only at frame start (IDLE->CONV, GAP->CONV). Changes mid-frame do not affect the current frame.
// - Single-bit mask: the same channel repeats every frame.
// - enable falling mid-frame: the frame completes, including any pending valid, then IDLE.
//   - The last config's result is discarded (primed cleared).
// - Frame length = CONV_CYCLES + 24*SCK_DIV + 1 + GAP_CYCLES cycles.
// - Latency: the result for a channel appears at the end of the frame after the one that configured it.
// - reset_n low at any point: immediate return to reset values. adc_convst/adc_sclk drop the same cycle; no partial sample emitted.
// CONFIGURATION
// - ADC_SCAN_AVG_EN defined: a per-channel 14-bit accumulator sums 4 consecutive raw results for that channel.
//   - sample_valid pulses only on every 4th result per channel, with sample_data = sum[13:2] (truncated mean).
//   - Accumulators and counters clear when primed is cleared and on reset.
// - ADC_SCAN_AVG_EN undefined: each raw result is emitted; no accumulator logic is synthesised.
// TESTING
// - Reset, then enable=1, ch_mask=8'h01, ADC model returns 12'hA5C:
//   - first frame gives no valid.
//   - each later frame gives valid with ch=0, data=12'hA5C.
//   - din word=6'b100010.
// - ch_mask=8'h24: config order ch2,ch5,ch2,...; din words 6'b100110, 6'b111010.
//   - valids tagged 2,5,2 lag config by one frame; period = 80+48+1+100 = 229 clk.
// - Mask changed 8'h01->8'h80 mid-SHIFT: current frame stays ch0; next config ch7; next valid ch=0, then ch=7.
// - enable dropped during CONV: frame completes, valid for prior channel emitted, FSM IDLE, busy=0.
//   - Re-enable: first frame emits no valid.
// - reset_n asserted mid-SHIFT: adc_sclk/adc_convst/sample_valid 0 in the same cycle, no valid.
//   - After release, first frame emits no valid.
// - ADC_SCAN_AVG_EN, ch_mask=8'h01, model returns 100,101,102,105: one valid, data=102; no valid on the other three frames.

Source files
------------

// File: rtl/adc_scan_sequencer.sv
// adc_scan_sequencer: round-robin scan controller for an LTC2308 SPI ADC.
// Optional ADC_SCAN_AVG_EN: emit the truncated mean of 4 results per channel.
module adc_scan_sequencer #(
  parameter int SCK_DIV     = 2,
  parameter int CONV_CYCLES = 80,
  parameter int GAP_CYCLES  = 100
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [7:0]  ch_mask,
  output logic        adc_convst,
  output logic        adc_sclk,
  output logic        adc_din,
  input  logic        adc_dout,
  output logic        sample_valid,
  output logic [2:0]  sample_ch,
  output logic [11:0] sample_data,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CONV  = 2'd1,
    SHIFT = 2'd2,
    GAP   = 2'd3
  } state_t;

  localparam logic [15:0] CONV_LAST = 16'(CONV_CYCLES - 1);
  localparam logic [15:0] DIV_LAST  = 16'(SCK_DIV - 1);
  localparam logic [15:0] GAP_LAST  =
    16'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [4:0]  EDGE_END  = 5'd24;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [4:0]  edge_q, edge_d;
  logic [2:0]  cur_ch_q, cur_ch_d;
  logic [2:0]  prev_ch_q, prev_ch_d;
  logic        primed_q, primed_d;
  logic        seeded_q, seeded_d;
  logic [11:0] shreg_q, shreg_d;

  logic        convst_q, convst_d;
  logic        sclk_q, sclk_d;
  logic        din_q, din_d;
  logic        valid_q, valid_d;
  logic [2:0]  ch_q, ch_d;
  logic [11:0] data_q, data_d;
  logic        busy_q, busy_d;

  logic [2:0]  srch_base, nxt_ch;
  logic        found, go, fin, frame_done;
  logic [11:0] cfg_word;

  assign go       = enable && (ch_mask != 8'h00);
  assign cfg_word = {1'b1, cur_ch_q[0], cur_ch_q[2], cur_ch_q[1],
                     1'b1, 1'b0, 6'b000000};

  // next enabled channel after the current one, wrapping 7->0
  always_comb begin
    srch_base = seeded_q ? cur_ch_q + 3'd1 : 3'd0;
    nxt_ch    = srch_base;
    found     = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (!found && ch_mask[srch_base + 3'(i)]) begin
        nxt_ch = srch_base + 3'(i);
        found  = 1'b1;
      end
    end
  end

  // frame sequencer: convert, shift config/result, gap, repeat
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    edge_d     = edge_q;
    cur_ch_d   = cur_ch_q;
    prev_ch_d  = prev_ch_q;
    primed_d   = primed_q;
    seeded_d   = seeded_q;
    shreg_d    = shreg_q;
    fin        = 1'b0;
    frame_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (go) begin
          state_d  = CONV;
          cnt_d    = '0;
          cur_ch_d = nxt_ch;
          seeded_d = 1'b1;
        end
      end
      CONV: begin
        if (cnt_q == CONV_LAST) begin
          state_d = SHIFT;
          cnt_d   = '0;
          edge_d  = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      SHIFT: begin
        if (edge_q == EDGE_END) begin
          prev_ch_d = cur_ch_q;
          primed_d  = 1'b1;
          cnt_d     = '0;
          if (GAP_CYCLES == 0) frame_done = 1'b1;
          else state_d = GAP;
        end else if (cnt_q == DIV_LAST) begin
          cnt_d  = '0;
          edge_d = edge_q + 5'd1;
          if (!edge_q[0]) shreg_d = {shreg_q[10:0], adc_dout};
          if (edge_q == 5'd23) fin = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) frame_done = 1'b1;
        else cnt_d = cnt_q + 16'd1;
      end
      default: state_d = IDLE;
    endcase
    if (frame_done) begin
      if (go) begin
        state_d  = CONV;
        cnt_d    = '0;
        cur_ch_d = nxt_ch;
      end else begin
        state_d  = IDLE;
        primed_d = 1'b0;
      end
    end
  end

  // pin outputs decoded from the next state so they leave flops
  always_comb begin
    convst_d = (state_d == CONV);
    sclk_d   = (state_d == SHIFT) && edge_d[0];
    busy_d   = (state_d != IDLE);
    din_d    = 1'b0;
    if (state_d == SHIFT && edge_d < EDGE_END)
      din_d = cfg_word[4'd11 - {1'b0, edge_d[4:2], edge_d[1]} ];
  end

`ifdef ADC_SCAN_AVG_EN
  logic [7:0][13:0] acc_q, acc_d;
  logic [7:0][1:0]  navg_q, navg_d;
  logic [13:0]      acc_sum;

  // accumulate 4 results per channel, emit their truncated mean
  always_comb begin
    acc_d   = acc_q;
    navg_d  = navg_q;
    valid_d = 1'b0;
    ch_d    = ch_q;
    data_d  = data_q;
    acc_sum = acc_q[prev_ch_q] + {2'b00, shreg_q};
    if (fin && primed_q) begin
      if (navg_q[prev_ch_q] == 2'd3) begin
        valid_d            = 1'b1;
        ch_d               = prev_ch_q;
        data_d             = acc_sum[13:2];
        acc_d[prev_ch_q]   = '0;
        navg_d[prev_ch_q]  = '0;
      end else begin
        acc_d[prev_ch_q]   = acc_sum;
        navg_d[prev_ch_q]  = navg_q[prev_ch_q] + 2'd1;
      end
    end
    if (frame_done && !go) begin
      acc_d  = '0;
      navg_d = '0;
    end
  end

  // averaging state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q  <= '0;
      navg_q <= '0;
    end else begin
      acc_q  <= acc_d;
      navg_q <= navg_d;
    end
  end
`else
  // raw result of the previous frame's channel
  always_comb begin
    valid_d = fin && primed_q;
    ch_d    = ch_q;
    data_d  = data_q;
    if (fin && primed_q) begin
      ch_d   = prev_ch_q;
      data_d = shreg_q;
    end
  end
`endif

  // state and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      edge_q    <= '0;
      cur_ch_q  <= '0;
      prev_ch_q <= '0;
      primed_q  <= 1'b0;
      seeded_q  <= 1'b0;
      shreg_q   <= '0;
      convst_q  <= 1'b0;
      sclk_q    <= 1'b0;
      din_q     <= 1'b0;
      valid_q   <= 1'b0;
      ch_q      <= '0;
      data_q    <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      edge_q    <= edge_d;
      cur_ch_q  <= cur_ch_d;
      prev_ch_q <= prev_ch_d;
      primed_q  <= primed_d;
      seeded_q  <= seeded_d;
      shreg_q   <= shreg_d;
      convst_q  <= convst_d;
      sclk_q    <= sclk_d;
      din_q     <= din_d;
      valid_q   <= valid_d;
      ch_q      <= ch_d;
      data_q    <= data_d;
      busy_q    <= busy_d;
    end
  end

  assign adc_convst   = convst_q;
  assign adc_sclk     = sclk_q;
  assign adc_din      = din_q;
  assign sample_valid = valid_q;
  assign sample_ch    = ch_q;
  assign sample_data  = data_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// tb_adc_scan_sequencer: frame-level reference model plus ADC pin model.
// Directed scenarios first, then randomized mask/enable/reset traffic.
module tb_adc_scan_sequencer;

  localparam int D      = 2;
  localparam int C      = 80;
  localparam int G      = 100;
  localparam int SH_END = C + 24 * D;
  localparam int F      = SH_END + 1 + G;

  logic        clk;
  logic        reset_n;
  logic        enable;
  logic [7:0]  ch_mask;
  logic        adc_convst, adc_sclk, adc_din, adc_dout;
  logic        sample_valid, busy;
  logic [2:0]  sample_ch;
  logic [11:0] sample_data;

  adc_scan_sequencer #(
    .SCK_DIV(D), .CONV_CYCLES(C), .GAP_CYCLES(G)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .ch_mask(ch_mask),
    .adc_convst(adc_convst), .adc_sclk(adc_sclk), .adc_din(adc_din),
    .adc_dout(adc_dout), .sample_valid(sample_valid),
    .sample_ch(sample_ch), .sample_data(sample_data), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // ADC pin model: word MSB first, next bit after each SCK fall
  logic [11:0] adc_word = 12'h000;
  int falls = 0;
  initial forever begin
    @(posedge adc_convst or negedge adc_sclk);
    if (adc_convst) falls = 0;
    else falls++;
  end
  always_comb begin
    adc_dout = 1'b0;
    if (falls < 12) adc_dout = adc_word[4'(11 - falls)];
  end

  // capture the 6 config bits seen at each SCK rise
  logic [5:0] cap = 6'd0;
  int nb = 0;
  logic [5:0] cfg_log[$];
  initial forever begin
    @(posedge adc_sclk or posedge adc_convst);
    if (adc_convst) nb = 0;
    else begin
      cap = {cap[4:0], adc_din};
      nb++;
      if (nb == 6) cfg_log.push_back(cap);
    end
  end

  // reference model state (frame position, not RTL encoding)
  bit          m_run, m_primed, m_seeded, m_val;
  int          m_off;
  logic [2:0]  m_ch, m_prev, m_vch;
  logic [11:0] m_vdata, m_word;
  int          asum[8];
  int          acnt[8];
  logic [11:0] wq[$];
  bit          fix_en = 1'b0;
  logic [11:0] fix_val = 12'h000;

  function automatic logic [2:0] pick_ch(input logic [7:0] m,
                                         input logic [2:0] st);
    logic [2:0] k;
    for (int i = 0; i < 8; i++) begin
      k = st + 3'(i);
      if (m[k]) return k;
    end
    return st;
  endfunction

  task automatic clr_avg();
    for (int i = 0; i < 8; i++) begin
      asum[i] = 0;
      acnt[i] = 0;
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_primed = 0; m_seeded = 0; m_val = 0;
    m_off = 0; m_ch = 0; m_prev = 0; m_vch = 0; m_vdata = 0;
    clr_avg();
  endtask

  task automatic start_frame(input logic [2:0] st);
    m_run    = 1;
    m_off    = 0;
    m_seeded = 1;
    m_ch     = pick_ch(ch_mask, st);
    if (wq.size() > 0) m_word = wq.pop_front();
    else if (fix_en) m_word = fix_val;
    else m_word = 12'($urandom);
    adc_word = m_word;
  endtask

  task automatic emit();
`ifdef ADC_SCAN_AVG_EN
    asum[m_prev] += int'(m_word);
    acnt[m_prev]++;
    if (acnt[m_prev] == 4) begin
      m_val   = 1;
      m_vch   = m_prev;
      m_vdata = 12'(asum[m_prev] / 4);
      asum[m_prev] = 0;
      acnt[m_prev] = 0;
    end
`else
    m_val   = 1;
    m_vch   = m_prev;
    m_vdata = m_word;
`endif
  endtask

  task automatic model_step();
    m_val = 0;
    if (!m_run) begin
      if (enable && ch_mask != 8'h00)
        start_frame(m_seeded ? m_ch + 3'd1 : 3'd0);
    end else begin
      if (m_off == SH_END) begin
        m_prev   = m_ch;
        m_primed = 1;
      end
      if (m_off == F - 1) begin
        if (enable && ch_mask != 8'h00) start_frame(m_ch + 3'd1);
        else begin
          m_run    = 0;
          m_primed = 0;
          clr_avg();
        end
      end else begin
        m_off++;
        if (m_off == SH_END && m_primed) emit();
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) model_reset();
      else model_step();
    end
  end

  // per-cycle comparison of every output against the model
  task automatic compare();
    int s;
    logic e_cv, e_sck, e_din, e_busy, sh;
    logic [11:0] cw;
    s      = m_off - C;
    e_busy = m_run;
    e_cv   = m_run && (m_off < C);
    sh     = m_run && (m_off >= C) && (m_off < SH_END);
    e_sck  = sh && (((s / D) % 2) == 1);
    cw     = {1'b1, m_ch[0], m_ch[2], m_ch[1], 1'b1, 1'b0, 6'b000000};
    e_din  = sh ? cw[4'(11 - s / (2 * D))] : 1'b0;
    checks++;
    if ({busy, adc_convst, adc_sclk, adc_din, sample_valid} !==
        {e_busy, e_cv, e_sck, e_din, m_val} ||
        (m_val && (sample_ch !== m_vch || sample_data !== m_vdata))) begin
      errors++;
      $display("FAIL cycle_compare @%0d: got b/cv/sck/din/v=%b%b%b%b%b ch=%0d d=%h, expected %b%b%b%b%b ch=%0d d=%h",
               cyc, busy, adc_convst, adc_sclk, adc_din, sample_valid,
               sample_ch, sample_data, e_busy, e_cv, e_sck, e_din,
               m_val, m_vch, m_vdata);
    end
  endtask

  initial forever begin
    @(negedge clk);
    compare();
  end

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_valid(input int lim, output logic [2:0] ch,
                            output logic [11:0] d, output int c);
    ch = 0; d = 0; c = 0;
    for (int k = 0; k < lim; k++) begin
      @(negedge clk);
      if (sample_valid === 1'b1) begin
        ch = sample_ch;
        d  = sample_data;
        c  = cyc;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL valid_timeout: got no sample_valid, required one within %0d cycles", lim);
  endtask

  // which: 0 = sclk high, 1 = convst high, 2 = busy low
  task automatic wait_sig(input int which, input int lim);
    for (int k = 0; k < lim; k++) begin
      @(negedge clk);
      if (which == 0 && adc_sclk === 1'b1) return;
      if (which == 1 && adc_convst === 1'b1) return;
      if (which == 2 && busy === 1'b0) return;
    end
    checks++;
    errors++;
    $display("FAIL wait_timeout: got no event %0d, required within %0d cycles", which, lim);
  endtask

  logic [2:0]  vch;
  logic [11:0] vd;
  int vc, pc, en_cyc, n0, r;

  initial begin
    reset_n = 1'b1;
    enable  = 1'b0;
    ch_mask = 8'h00;
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_convst", adc_convst, 0);
    check("rst_sclk", adc_sclk, 0);
    check("rst_din", adc_din, 0);
    check("rst_valid", sample_valid, 0);
    check("rst_ch", sample_ch, 0);
    check("rst_data", sample_data, 0);
    check("rst_busy", busy, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

`ifdef ADC_SCAN_AVG_EN
    wq = '{12'd0, 12'd100, 12'd101, 12'd102, 12'd105};
    n0 = cfg_log.size();
    en_cyc = cyc;
    enable = 1'b1;
    ch_mask = 8'h01;
    wait_valid(6 * F, vch, vd, vc);
    check("avg_latency", vc - en_cyc, 1 + 4 * F + SH_END);
    check("avg_ch", vch, 0);
    check("avg_data", vd, 102);
    check("avg_cfg", cfg_log[n0], 6'b100010);
    enable = 1'b0;
    wait_sig(2, 2 * F);
`else
    fix_en  = 1'b1;
    fix_val = 12'hA5C;
    n0 = cfg_log.size();
    en_cyc = cyc;
    enable = 1'b1;
    ch_mask = 8'h01;
    wait_valid(2 * F, vch, vd, vc);
    check("a_first_latency", vc - en_cyc, 358);
    check("a_ch", vch, 0);
    check("a_data", vd, 12'hA5C);
    pc = vc;
    wait_valid(F + 10, vch, vd, vc);
    check("a_period", vc - pc, 229);
    check("a_data2", vd, 12'hA5C);
    check("a_cfg", cfg_log[n0], 6'b100010);

    wait_sig(1, F);
    enable = 1'b0;
    wait_valid(F, vch, vd, vc);
    check("drop_ch", vch, 0);
    check("drop_data", vd, 12'hA5C);
    wait_sig(2, F);
    check("drop_busy", busy, 0);

    fix_en = 1'b0;
    n0 = cfg_log.size();
    @(negedge clk);
    ch_mask = 8'h24;
    en_cyc = cyc;
    enable = 1'b1;
    wait_valid(2 * F, vch, vd, vc);
    check("b_reenable_latency", vc - en_cyc, 358);
    check("b_ch0", vch, 2);
    pc = vc;
    wait_valid(F + 10, vch, vd, vc);
    check("b_ch1", vch, 5);
    check("b_period", vc - pc, 229);
    check("b_cfg0", cfg_log[n0], 6'b100110);
    check("b_cfg1", cfg_log[n0 + 1], 6'b111010);
    check("b_cfg2", cfg_log[n0 + 2], 6'b100110);
    enable = 1'b0;
    wait_sig(2, 2 * F);

    n0 = cfg_log.size();
    ch_mask = 8'h01;
    enable = 1'b1;
    wait_sig(0, F);
    ch_mask = 8'h80;
    wait_valid(2 * F, vch, vd, vc);
    check("c_ch0", vch, 0);
    wait_valid(F + 10, vch, vd, vc);
    check("c_ch1", vch, 7);
    check("c_cfg0", cfg_log[n0], 6'b100010);
    check("c_cfg1", cfg_log[n0 + 1], 6'b111110);

    wait_sig(0, F + 10);
    #2 reset_n = 1'b0;
    #1;
    check("d_rst_sclk", adc_sclk, 0);
    check("d_rst_convst", adc_convst, 0);
    check("d_rst_valid", sample_valid, 0);
    check("d_rst_busy", busy, 0);
    repeat (3) @(negedge clk);
    en_cyc = cyc;
    reset_n = 1'b1;
    wait_valid(2 * F, vch, vd, vc);
    check("d_post_rst_latency", vc - en_cyc, 358);
    check("d_post_rst_ch", vch, 7);
`endif

    fix_en = 1'b0;
    for (int seg = 0; seg < 30; seg++) begin
      @(negedge clk);
      r = $urandom_range(0, 9);
      if (r == 0) ch_mask = 8'h00;
      else if (r < 4) ch_mask = 8'(1 << $urandom_range(0, 7));
      else ch_mask = 8'($urandom);
      enable = ($urandom_range(0, 4) != 0);
      if (seg == 15) begin
        #2 reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
      end
      repeat ($urandom_range(20, 700)) @(negedge clk);
    end
    enable = 1'b0;
    wait_sig(2, 2 * F);
    check("end_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
